instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 155 +++++++++++++++
 tb/tb_instr_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time instruction loader: packs a little-endian byte stream into 32-bit words,
// writes them to instruction memory from OFFSET upward and holds the core until done.
module instr_loader #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              SIZE          = 12,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET        = 32'hBFC00000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    input  logic                     byte_last,
    output logic                     byte_ready,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]    wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error,
    output logic [SIZE-2:0]          word_count
);

    localparam logic [SIZE-2:0] CAP_WORDS = (SIZE-1)'(2 ** (SIZE - 2));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [1:0]                 r_byte_idx;
    logic [DATA_WIDTH-1:0]      r_asm;
    logic                       r_final;
    logic [SIZE-2:0]            r_word_count;
    logic [ADDRESS_WIDTH-1:0]   r_waddr;
    logic [DATA_WIDTH-1:0]      r_wdata;

    logic                       w_full;
    logic                       w_accept;
    logic                       w_word_end;
    logic                       w_restart;
    logic [DATA_WIDTH-1:0]      w_asm_next;
    logic [ADDRESS_WIDTH-1:0]   w_word_addr;

    assign w_full      = (r_word_count == CAP_WORDS);
    assign w_accept    = byte_valid && byte_ready;
    assign w_word_end  = w_accept && ((r_byte_idx == 2'd3) || byte_last);
    assign w_restart   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERROR));
    assign w_word_addr = OFFSET + ADDRESS_WIDTH'({r_word_count, 2'b00});

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{r_byte_idx, 3'b000} +: 8] = byte_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register
            // samples pre-edge values regardless of block ordering.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        byte_ready   = 1'b0;
        we           = 1'b0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                cpu_hold   = 1'b1;
                byte_ready = !w_full;
                if (w_full) begin
                    if (byte_valid) w_next_state = ST_ERROR;
                end else if (w_word_end) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cpu_hold     = 1'b1;
                we           = 1'b1;
                w_next_state = r_final ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) w_next_state = ST_LOAD;
            end
            ST_ERROR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
                if (start) w_next_state = ST_LOAD;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Address and data are captured with the completing byte so they are already
    // stable in the WRITE cycle and keep their value afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_final      <= 1'b0;
            r_word_count <= '0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else if (w_restart) begin
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_final      <= 1'b0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_asm      <= w_asm_next;
                        if (byte_last) r_final <= 1'b1;
                        if (w_word_end) begin
                            r_waddr <= w_word_addr;
                            r_wdata <= w_asm_next;
                        end
                    end
                end
                ST_WRITE: begin
                    r_word_count <= r_word_count + 1'b1;
                    r_byte_idx   <= '0;
                    r_asm        <= '0;
                end
                default: ;
            endcase
        end
    end

    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a default-size instance for normal loads and a
// SIZE=4 instance for the overflow case; monitors pop expected writes as they appear.
module tb_instr_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_last = 1'b0;
    logic        sel_small = 1'b0;

    logic        ready_a, we_a, hold_a, done_a, err_a;
    logic [31:0] waddr_a, wdata_a;
    logic [10:0] wc_a;
    logic        ready_b, we_b, hold_b, done_b, err_b;
    logic [31:0] waddr_b, wdata_b;
    logic [2:0]  wc_b;

    wr_t exp_a[$];
    wr_t exp_b[$];
    int  n_checks = 0;
    int  n_errors = 0;
    logic [7:0] stim [17];

    always #5 clk = ~clk;

    instr_loader dut_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel_small), .byte_in(byte_in),
        .byte_valid(byte_valid & ~sel_small), .byte_last(byte_last),
        .byte_ready(ready_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .cpu_hold(hold_a), .done(done_a), .error(err_a), .word_count(wc_a)
    );

    instr_loader #(.SIZE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel_small), .byte_in(byte_in),
        .byte_valid(byte_valid & sel_small), .byte_last(byte_last),
        .byte_ready(ready_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .cpu_hold(hold_b), .done(done_b), .error(err_b), .word_count(wc_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_a(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_a.push_back(w);
    endfunction

    function automatic void push_b(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_b.push_back(w);
    endfunction

    // Monitors: every write must match the next expected entry, with byte_ready low.
    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_write", {waddr_a, wdata_a}, 64'h0);
            end else begin
                wr_t e;
                e = exp_a.pop_front();
                check("a_waddr", waddr_a, e.addr);
                check("a_wdata", wdata_a, e.data);
            end
            check("a_ready_in_write", ready_a, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (we_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_write", {waddr_b, wdata_b}, 64'h0);
            end else begin
                wr_t e;
                e = exp_b.pop_front();
                check("b_waddr", waddr_b, e.addr);
                check("b_wdata", wdata_b, e.data);
            end
            check("b_ready_in_write", ready_b, 1'b0);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offers one byte and returns 1ns after the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
        int budget;
        logic rdy;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        byte_in    = b;
        byte_last  = last;
        byte_valid = 1'b1;
        budget     = 0;
        forever begin
            @(negedge clk);
            rdy = sel_small ? ready_b : ready_a;
            if (rdy) begin
                @(posedge clk);
                #1;
                break;
            end
            budget++;
            if (budget > 50) begin
                check("byte_accept_timeout", 1'b1, 1'b0);
                break;
            end
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_stream(input int n, input bit with_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            logic is_last;
            is_last = with_last && (i == n - 1);
            send_byte(stim[i], is_last, gaps);
            if ((i % 4) == 3 || is_last)
                check("we_latency", sel_small ? we_b : we_a, 1'b1);
        end
    endtask

    task automatic wait_done_a();
        int budget = 0;
        while (done_a !== 1'b1) begin
            @(negedge clk);
            budget++;
            if (budget > 50) begin
                check("done_timeout", done_a, 1'b1);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, ready_a, 1'b0);
        check({tag, "_we"},         we_a,    1'b0);
        check({tag, "_cpu_hold"},   hold_a,  1'b0);
        check({tag, "_done"},       done_a,  1'b0);
        check({tag, "_error"},      err_a,   1'b0);
        check({tag, "_word_count"}, wc_a,    11'd0);
        check({tag, "_waddr"},      waddr_a, 32'h0);
        check({tag, "_wdata"},      wdata_a, 32'h0);
    endtask

    task automatic load_basic_stim();
        stim[0] = 8'h13; stim[1] = 8'h05; stim[2] = 8'h00; stim[3] = 8'h00;
        stim[4] = 8'h93; stim[5] = 8'h00; stim[6] = 8'h10; stim[7] = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, both instances.
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        check("reset_b_hold", hold_b, 1'b0);
        check("reset_b_wc", wc_b, 3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_cpu_hold", hold_a, 1'b0);

        // Basic two-word load.
        load_basic_stim();
        push_a(32'hBFC00000, 32'h00000513);
        push_a(32'hBFC00004, 32'h00100093);
        pulse_start();
        check("load_cpu_hold", hold_a, 1'b1);
        send_stream(8, 1'b1, 1'b0);
        wait_done_a();
        check("basic_done", done_a, 1'b1);
        check("basic_word_count", wc_a, 11'd2);
        check("basic_cpu_hold", hold_a, 1'b0);
        check("basic_drained", exp_a.size(), 0);

        // Reload from DONE, then a partial word.
        pulse_start();
        check("reload_done_cleared", done_a, 1'b0);
        check("reload_word_count", wc_a, 11'd0);
        stim[0] = 8'h37; stim[1] = 8'h12;
        push_a(32'hBFC00000, 32'h00001237);
        send_stream(2, 1'b1, 1'b0);
        wait_done_a();
        check("partial_done", done_a, 1'b1);
        check("partial_word_count", wc_a, 11'd1);

        // Backpressure: random gaps in byte_valid.
        load_basic_stim();
        push_a(32'hBFC00000, 32'h00000513);
        push_a(32'hBFC00004, 32'h00100093);
        pulse_start();
        send_stream(8, 1'b1, 1'b1);
        wait_done_a();
        check("bp_done", done_a, 1'b1);
        check("bp_word_count", wc_a, 11'd2);
        check("bp_drained", exp_a.size(), 0);

        // Reset after six bytes: first word written, second abandoned.
        push_a(32'hBFC00000, 32'h00000513);
        pulse_start();
        send_stream(6, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset_one_write", exp_a.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_idle_hold", hold_a, 1'b0);

        // Overflow on the 4-word instance.
        sel_small = 1'b1;
        for (int i = 0; i < 16; i++) stim[i] = 8'h10 + 8'(i);
        push_b(32'hBFC00000, 32'h13121110);
        push_b(32'hBFC00004, 32'h17161514);
        push_b(32'hBFC00008, 32'h1B1A1918);
        push_b(32'hBFC0000C, 32'h1F1E1D1C);
        pulse_start();
        send_stream(16, 1'b0, 1'b0);
        begin
            bit saw_ready = 1'b0;
            byte_in    = 8'h20;
            byte_last  = 1'b0;
            byte_valid = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (ready_b) saw_ready = 1'b1;
                if (err_b) break;
            end
            byte_valid = 1'b0;
            check("ovf_17th_not_accepted", saw_ready, 1'b0);
        end
        check("ovf_error", err_b, 1'b1);
        check("ovf_cpu_hold", hold_b, 1'b1);
        check("ovf_ready", ready_b, 1'b0);
        check("ovf_word_count", wc_b, 3'd4);
        check("ovf_four_writes", exp_b.size(), 0);
        @(posedge clk);
        #1;
        pulse_start();
        check("ovf_restart_error_cleared", err_b, 1'b0);
        check("ovf_restart_word_count", wc_b, 3'd0);
        sel_small = 1'b0;

        repeat (3) @(posedge clk);
        check("final_a_drained", exp_a.size(), 0);
        check("final_b_drained", exp_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
